// File: rtl/sfp_pkg.sv
// rtl/sfp_pkg.sv - shared states and defaults for the SFP EEPROM reader
package sfp_pkg;

  localparam int         CLK_DIV_DEFAULT  = 250;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_WR_DEV,
    ST_WR_ADDR,
    ST_RESTART,
    ST_WR_DEVR,
    ST_RD_BYTE,
    ST_MNACK,
    ST_STOP
  } state_t;

  function automatic logic is_write_state(input state_t s);
    return (s == ST_WR_DEV) || (s == ST_WR_ADDR) || (s == ST_WR_DEVR);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - quarter-bit tick generator, held at zero while disabled
module i2c_tick_gen
  import sfp_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(CLK_DIV - 1));
  assign tick = en && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sfp_eeprom_reader.sv
// rtl/sfp_eeprom_reader.sv - I2C random-read master for one SFP ID EEPROM byte
module sfp_eeprom_reader
  import sfp_pkg::*;
#(
  parameter int         CLK_DIV  = CLK_DIV_DEFAULT,
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       ack_err,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl
);

  state_t     state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d, addr_q, addr_d, data_q, data_d;
  logic       busy_q, busy_d, ack_err_q, ack_err_d;
  logic       tick, accept, done_w;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_q),
    .tick (tick)
  );

  assign accept  = start && !busy_q;
  assign done_w  = busy_q && tick && (qtr_q == 2'd3) && (state_q == ST_STOP);
  assign done    = done_w;
  assign busy    = busy_q && !done_w;
  assign ack_err = ack_err_q;
  // Present the fresh byte already in the done cycle, not one cycle later.
  assign data    = (done_w && !ack_err_q) ? rx_q : data_q;

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    ack_err_d = ack_err_q;
    if (accept) begin
      state_d   = ST_START;
      qtr_d     = 2'd0;
      bit_d     = 4'd0;
      addr_d    = addr;
      busy_d    = 1'b1;
      ack_err_d = 1'b0;
    end else if (busy_q && tick) begin
      qtr_d = qtr_q + 2'd1;
      if (qtr_q == 2'd2) begin
        if (is_write_state(state_q) && bit_q == 4'd8 && sda_in) ack_err_d = 1'b1;
        if (state_q == ST_RD_BYTE) rx_d = {rx_q[6:0], sda_in};
      end
      if (qtr_q == 2'd3) begin
        case (state_q)
          ST_START: begin
            state_d = ST_WR_DEV;
            bit_d   = 4'd0;
            tx_d    = {DEV_ADDR, 1'b0};
          end
          ST_WR_DEV, ST_WR_ADDR, ST_WR_DEVR: begin
            if (bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
              tx_d  = {tx_q[6:0], 1'b0};
            end else if (ack_err_q) begin
              state_d = ST_STOP;
            end else begin
              bit_d = 4'd0;
              case (state_q)
                ST_WR_DEV: begin
                  state_d = ST_WR_ADDR;
                  tx_d    = addr_q;
                end
                ST_WR_ADDR: state_d = ST_RESTART;
                default:    state_d = ST_RD_BYTE;
              endcase
            end
          end
          ST_RESTART: begin
            state_d = ST_WR_DEVR;
            bit_d   = 4'd0;
            tx_d    = {DEV_ADDR, 1'b1};
          end
          ST_RD_BYTE: begin
            if (bit_q == 4'd7) state_d = ST_MNACK;
            else               bit_d   = bit_q + 4'd1;
          end
          ST_MNACK: state_d = ST_STOP;
          ST_STOP: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (!ack_err_q) data_d = rx_q;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // SCL stays high through START; RESTART raises it at q1 so SDA can fall at q2 under a high SCL.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state_q)
      ST_START:   sda_oe = qtr_q[1];
      ST_RESTART: begin
        scl    = (qtr_q != 2'd0);
        sda_oe = qtr_q[1];
      end
      ST_WR_DEV, ST_WR_ADDR, ST_WR_DEVR: begin
        scl    = qtr_q[1];
        sda_oe = (bit_q != 4'd8) && !tx_q[7];
      end
      ST_RD_BYTE, ST_MNACK: scl = qtr_q[1];
      ST_STOP: begin
        scl    = qtr_q[1];
        sda_oe = (qtr_q != 2'd3);
      end
      default: begin
        scl    = 1'b1;
        sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      qtr_q     <= 2'd0;
      bit_q     <= 4'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      ack_err_q <= ack_err_d;
    end
  end

endmodule

// File: tb/tb_sfp_eeprom_reader.sv
// tb/tb_sfp_eeprom_reader.sv - directed bench with a behavioural open-drain EEPROM slave
module tb_sfp_eeprom_reader;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] addr;
  logic       busy, done, ack_err;
  logic [7:0] data;
  logic       sda_in, sda_oe, scl;
  logic       s_oe;

  int n_cmp = 0;
  int n_bad = 0;

  // slave configuration, written only by the stimulus process
  bit         slave_present = 1'b1;
  int         nack_idx = -1;
  logic [7:0] rd_val = 8'h00;

  // slave observations, written only by the slave process
  logic [7:0] bus_bytes[$];
  int         start_cnt = 0;
  int         stop_cnt = 0;

  always #5 clk = ~clk;

  assign sda_in = ~(sda_oe | s_oe);

  sfp_eeprom_reader #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h50)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .busy    (busy),
    .done    (done),
    .data    (data),
    .ack_err (ack_err),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .scl     (scl)
  );

  initial begin
    int         s_phase, s_bit, s_idx;
    bit         s_got, s_first, s_go_rd, ok;
    logic [7:0] s_sh;
    logic       sc, sd, p_scl, p_sda;
    s_oe = 1'b0; s_phase = 0; s_bit = 0; s_idx = 0; s_got = 0; s_first = 0; s_go_rd = 0;
    s_sh = 8'h00; p_scl = 1'b1; p_sda = 1'b1;
    forever begin
      @(negedge clk);
      sc = scl;
      sd = sda_in;
      if (rst === 1'b1) begin
        s_oe = 1'b0; s_phase = 0; s_got = 0; s_idx = 0;
      end else if (p_scl && sc && p_sda && !sd) begin
        start_cnt++;
        s_phase = 1; s_bit = 0; s_got = 0; s_sh = 8'h00; s_first = 1; s_go_rd = 0; s_oe = 1'b0;
      end else if (p_scl && sc && !p_sda && sd) begin
        stop_cnt++;
        s_phase = 0; s_oe = 1'b0; s_idx = 0;
      end else if (!p_scl && sc) begin
        if (s_phase == 1 && s_bit < 8) s_sh = {s_sh[6:0], sd};
        s_got = 1;
      end else if (p_scl && !sc && s_got) begin
        s_got = 0;
        if (s_phase == 1) begin
          if (s_bit == 7) begin
            bus_bytes.push_back(s_sh);
            ok = slave_present && (s_idx != nack_idx) && (!s_first || s_sh[7:1] == 7'h50);
            s_go_rd = ok && s_first && s_sh[0];
            s_first = 0;
            s_idx++;
            s_oe = ok;
            s_bit = 8;
          end else if (s_bit == 8) begin
            s_oe = 1'b0;
            s_bit = 0;
            if (s_go_rd) begin
              s_phase = 2;
              s_oe = !rd_val[7];
            end
          end else begin
            s_bit++;
          end
        end else if (s_phase == 2) begin
          if (s_bit < 7) begin
            s_bit++;
            s_oe = !rd_val[7 - s_bit];
          end else if (s_bit == 7) begin
            s_bit = 8;
            s_oe = 1'b0;
          end else begin
            s_phase = 0;
            s_oe = 1'b0;
          end
        end
      end
      p_scl = sc;
      p_sda = sd;
    end
  end

  // Issues one start, optionally re-pulses start while busy and/or in the done cycle,
  // then watches 40 more cycles for stray done pulses or busy.
  task automatic run_txn(input logic [7:0] a, input int extra_at, input bit hold_in_done,
                         output int lat, output logic d_busy, output logic [7:0] d_data,
                         output logic d_ack, output int extra_done, output int busy_after);
    @(posedge clk); #1;
    start = 1'b1; addr = a;
    @(posedge clk); #1;
    start = 1'b0; addr = 8'hEE;
    lat = 1;
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_rise: busy=%b required 1", busy); n_bad++;
    end
    while (done !== 1'b1 && lat < 1500) begin
      start = (lat == extra_at);
      if (lat == extra_at) addr = 8'h33;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    d_busy = busy; d_data = data; d_ack = ack_err;
    if (hold_in_done) start = 1'b1;
    extra_done = 0; busy_after = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) extra_done++;
      if (busy !== 1'b0) busy_after++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; addr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)    begin $display("FAIL rst_busy: got %b required 0", busy); n_bad++; end
    n_cmp++; if (done !== 1'b0)    begin $display("FAIL rst_done: got %b required 0", done); n_bad++; end
    n_cmp++; if (data !== 8'h00)   begin $display("FAIL rst_data: got %h required 00", data); n_bad++; end
    n_cmp++; if (ack_err !== 1'b0) begin $display("FAIL rst_ack_err: got %b required 0", ack_err); n_bad++; end
    n_cmp++; if (sda_oe !== 1'b0)  begin $display("FAIL rst_sda_oe: got %b required 0", sda_oe); n_bad++; end
    n_cmp++; if (scl !== 1'b1)     begin $display("FAIL rst_scl: got %b required 1", scl); n_bad++; end
    rst = 1'b0;
  endtask

  task automatic test_read();
    int lat, xd, ba, base, s0, p0;
    logic db, da;
    logic [7:0] dd;
    logic [7:0] exp_bytes[3] = '{8'hA0, 8'h14, 8'hA1};
    slave_present = 1'b1; nack_idx = -1; rd_val = 8'hA5;
    base = bus_bytes.size(); s0 = start_cnt; p0 = stop_cnt;
    run_txn(8'h14, 0, 1'b0, lat, db, dd, da, xd, ba);
    n_cmp++; if (lat !== 624)  begin $display("FAIL read_latency: got %0d required 624", lat); n_bad++; end
    n_cmp++; if (dd !== 8'hA5) begin $display("FAIL read_data: got %h required a5", dd); n_bad++; end
    n_cmp++; if (da !== 1'b0)  begin $display("FAIL read_ack_err: got %b required 0", da); n_bad++; end
    n_cmp++; if (db !== 1'b0)  begin $display("FAIL read_busy_in_done: got %b required 0", db); n_bad++; end
    n_cmp++; if (xd !== 0)     begin $display("FAIL read_extra_done: got %0d required 0", xd); n_bad++; end
    n_cmp++; if (bus_bytes.size() - base !== 3) begin
      $display("FAIL read_byte_count: got %0d required 3", bus_bytes.size() - base); n_bad++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (bus_bytes[base + i] !== exp_bytes[i]) begin
          $display("FAIL read_byte%0d: got %h required %h", i, bus_bytes[base + i], exp_bytes[i]); n_bad++;
        end
      end
    end
    n_cmp++; if (start_cnt - s0 !== 2) begin $display("FAIL read_starts: got %0d required 2", start_cnt - s0); n_bad++; end
    n_cmp++; if (stop_cnt - p0 !== 1)  begin $display("FAIL read_stops: got %0d required 1", stop_cnt - p0); n_bad++; end
    n_cmp++; if (data !== 8'hA5)       begin $display("FAIL read_data_held: got %h required a5", data); n_bad++; end
  endtask

  task automatic test_absent();
    int lat, xd, ba, base, p0;
    logic db, da;
    logic [7:0] dd;
    slave_present = 1'b0; nack_idx = -1; rd_val = 8'h5A;
    base = bus_bytes.size(); p0 = stop_cnt;
    run_txn(8'h20, 0, 1'b0, lat, db, dd, da, xd, ba);
    n_cmp++; if (lat !== 176)  begin $display("FAIL absent_latency: got %0d required 176", lat); n_bad++; end
    n_cmp++; if (da !== 1'b1)  begin $display("FAIL absent_ack_err: got %b required 1", da); n_bad++; end
    n_cmp++; if (dd !== 8'hA5) begin $display("FAIL absent_data: got %h required a5", dd); n_bad++; end
    n_cmp++; if (db !== 1'b0)  begin $display("FAIL absent_busy: got %b required 0", db); n_bad++; end
    n_cmp++; if (bus_bytes.size() - base !== 1) begin
      $display("FAIL absent_byte_count: got %0d required 1", bus_bytes.size() - base); n_bad++;
    end
    n_cmp++; if (stop_cnt - p0 !== 1) begin $display("FAIL absent_stops: got %0d required 1", stop_cnt - p0); n_bad++; end
    n_cmp++; if (xd !== 0)     begin $display("FAIL absent_extra_done: got %0d required 0", xd); n_bad++; end
    slave_present = 1'b1;
  endtask

  task automatic test_nack_addr();
    int lat, xd, ba, base, p0;
    logic db, da;
    logic [7:0] dd;
    slave_present = 1'b1; nack_idx = 1; rd_val = 8'h77;
    base = bus_bytes.size(); p0 = stop_cnt;
    run_txn(8'h14, 0, 1'b0, lat, db, dd, da, xd, ba);
    n_cmp++; if (lat !== 320)  begin $display("FAIL nack_latency: got %0d required 320", lat); n_bad++; end
    n_cmp++; if (da !== 1'b1)  begin $display("FAIL nack_ack_err: got %b required 1", da); n_bad++; end
    n_cmp++; if (dd !== 8'hA5) begin $display("FAIL nack_data: got %h required a5", dd); n_bad++; end
    n_cmp++; if (bus_bytes.size() - base !== 2) begin
      $display("FAIL nack_byte_count: got %0d required 2", bus_bytes.size() - base); n_bad++;
    end
    n_cmp++; if (stop_cnt - p0 !== 1) begin $display("FAIL nack_stops: got %0d required 1", stop_cnt - p0); n_bad++; end
    n_cmp++; if (xd !== 0)      begin $display("FAIL nack_extra_done: got %0d required 0", xd); n_bad++; end
    n_cmp++; if (ack_err !== 1'b1) begin $display("FAIL nack_ack_err_held: got %b required 1", ack_err); n_bad++; end
    nack_idx = -1;
  endtask

  task automatic test_back_to_back();
    int lat, xd, ba, base, s0;
    logic db, da;
    logic [7:0] dd;
    slave_present = 1'b1; nack_idx = -1; rd_val = 8'hC3;
    base = bus_bytes.size(); s0 = start_cnt;
    run_txn(8'h14, 100, 1'b1, lat, db, dd, da, xd, ba);
    n_cmp++; if (lat !== 624)  begin $display("FAIL b2b_latency: got %0d required 624", lat); n_bad++; end
    n_cmp++; if (dd !== 8'hC3) begin $display("FAIL b2b_data: got %h required c3", dd); n_bad++; end
    n_cmp++; if (da !== 1'b0)  begin $display("FAIL b2b_ack_err_cleared: got %b required 0", da); n_bad++; end
    n_cmp++; if (xd !== 0)     begin $display("FAIL b2b_extra_done: got %0d required 0", xd); n_bad++; end
    n_cmp++; if (ba !== 0)     begin $display("FAIL b2b_start_in_done: busy cycles %0d required 0", ba); n_bad++; end
    n_cmp++; if (bus_bytes.size() - base !== 3) begin
      $display("FAIL b2b_byte_count: got %0d required 3", bus_bytes.size() - base); n_bad++;
    end else begin
      n_cmp++;
      if (bus_bytes[base + 1] !== 8'h14) begin
        $display("FAIL b2b_addr_byte: got %h required 14", bus_bytes[base + 1]); n_bad++;
      end
    end
    n_cmp++; if (start_cnt - s0 !== 2) begin $display("FAIL b2b_starts: got %0d required 2", start_cnt - s0); n_bad++; end
  endtask

  task automatic test_reset_mid();
    int lat, xd, ba, base, s0, n_done;
    logic db, da;
    logic [7:0] dd;
    slave_present = 1'b1; nack_idx = -1; rd_val = 8'h99;
    @(posedge clk); #1;
    start = 1'b1; addr = 8'h14;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; n_done = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) n_done++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (scl !== 1'b1)    begin $display("FAIL rmid_scl: got %b required 1", scl); n_bad++; end
    n_cmp++; if (sda_oe !== 1'b0) begin $display("FAIL rmid_sda_oe: got %b required 0", sda_oe); n_bad++; end
    n_cmp++; if (busy !== 1'b0)   begin $display("FAIL rmid_busy: got %b required 0", busy); n_bad++; end
    n_cmp++; if (data !== 8'h00)  begin $display("FAIL rmid_data: got %h required 00", data); n_bad++; end
    rst = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin $display("FAIL rmid_no_done: got %0d required 0", n_done); n_bad++; end
    rd_val = 8'h3C;
    base = bus_bytes.size(); s0 = start_cnt;
    run_txn(8'h60, 0, 1'b0, lat, db, dd, da, xd, ba);
    n_cmp++; if (lat !== 624)  begin $display("FAIL rmid_latency: got %0d required 624", lat); n_bad++; end
    n_cmp++; if (dd !== 8'h3C) begin $display("FAIL rmid_data_after: got %h required 3c", dd); n_bad++; end
    n_cmp++; if (da !== 1'b0)  begin $display("FAIL rmid_ack_err: got %b required 0", da); n_bad++; end
    n_cmp++; if (start_cnt - s0 !== 2) begin $display("FAIL rmid_starts: got %0d required 2", start_cnt - s0); n_bad++; end
    n_cmp++; if (bus_bytes.size() - base !== 3) begin
      $display("FAIL rmid_byte_count: got %0d required 3", bus_bytes.size() - base); n_bad++;
    end else begin
      n_cmp++;
      if (bus_bytes[base + 1] !== 8'h60) begin
        $display("FAIL rmid_addr_byte: got %h required 60", bus_bytes[base + 1]); n_bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_absent();
    test_nack_addr();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sfp_eeprom_reader.md
SFP_EEPROM_READER -- requirements
Module: sfp_eeprom_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250, meaning clk cycles per I2C quarter-bit (100 kHz SCL at 100 MHz clk).
REQ-002 SHALL have parameter DEV_ADDR, default 7'h50, meaning the 7-bit I2C address of the SFP ID EEPROM.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request one random-read; sampled only when busy=0.
REQ-006 SHALL have port addr  input  8  EEPROM byte address, captured with start.
REQ-007 SHALL have port busy  output  1  transaction in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-009 SHALL have port data  output  8  byte read; updated only on successful completion.
REQ-010 SHALL have port ack_err  output  1  last transaction saw a NACK on a written byte; valid with done, held until next start.
REQ-011 SHALL have port sda_in  input  1  sampled SDA line.
REQ-012 SHALL have port sda_oe  output  1  1 = pull SDA low; 0 = release (open drain).
REQ-013 SHALL have port scl  output  1  SCL drive; push-pull, no clock stretching.

Function
REQ-014 SHALL generate a quarter-bit tick every CLK_DIV cycles while busy; counter cleared on start accept.
REQ-015 SHALL run states IDLE -> START -> WR_DEV -> WR_ADDR -> RESTART -> WR_DEVR -> RD_BYTE -> MNACK -> STOP -> IDLE.
REQ-016 SHALL make each bit period exactly 4 ticks: SCL low q0-q1, high q2-q3; SDA changes only at q0, sampled at q2.
REQ-017 START/RESTART SHALL take one bit period: SDA released, SCL high, SDA pulled low at q2 with SCL high.
REQ-018 WR_DEV SHALL send {DEV_ADDR,0}, WR_ADDR SHALL send addr, WR_DEVR SHALL send {DEV_ADDR,1}, MSB first, each followed by one ACK bit period with sda_oe=0.
REQ-019 RD_BYTE SHALL shift 8 bits MSB first from sda_in at q2 of each bit; MNACK SHALL release SDA for one bit period.
REQ-020 STOP SHALL take one bit period: SDA low at q0, SCL high at q2, SDA released at q3.
REQ-021 Full transaction SHALL be 39 bit periods; done SHALL pulse exactly 156*CLK_DIV cycles after the start-accept cycle.
REQ-022 ACK sampled high after WR_DEV, WR_ADDR or WR_DEVR SHALL go directly to STOP, set ack_err=1, leave data unchanged, pulse done.
REQ-023 start while busy=1 SHALL be ignored; start in the done cycle SHALL be ignored (busy deasserts with done).
REQ-024 busy SHALL rise in the cycle after start is sampled and fall in the done cycle.
REQ-025 In IDLE, scl SHALL be 1 and sda_oe SHALL be 0.

Reset
REQ-026 rst SHALL force, in the next cycle: state IDLE, busy=0, done=0, data=8'h00, ack_err=0, sda_oe=0, scl=1, tick counter 0.
REQ-027 rst mid-transaction SHALL abort without a STOP and without a done pulse; the next start SHALL begin with a full START condition.

Structure
REQ-028 State enum, DEV_ADDR default and CLK_DIV default SHALL live in shared package sfp_pkg.
REQ-029 Quarter-tick counter SHALL be sub-module i2c_tick_gen (inputs clk, rst, en; output tick).

Verification
REQ-030 Bench SHALL use CLK_DIV=4 and a behavioural EEPROM slave at 0x50 with open-drain pull-up SDA model.
REQ-031 start, addr=8'h14, slave byte 8'hA5 -> bus bytes A0,14,A1; data=8'hA5, ack_err=0, done exactly 624 cycles after accept.
REQ-032 slave absent (never ACKs) -> STOP after first byte, ack_err=1, data unchanged, done pulse, busy=0.
REQ-033 slave NACKs addr byte only -> STOP after WR_ADDR, ack_err=1, one done pulse.
REQ-034 start pulsed again while busy -> ignored; exactly one transaction on the bus, one done pulse.
REQ-035 rst asserted at cycle 300 of a read -> next cycle scl=1, sda_oe=0, busy=0, no done; following start with addr=8'h60 completes with correct data.
